video_timing_det: RTL

- Receive-side counterpart of the video test pattern generator.
- Samples a parallel video stream (dout/en/hs/vs style, all active-high) and measures its timing geometry frame by frame.
- Declares lock once consecutive frames match, and flags loss of lock.
- Sits at sensor/TPG outputs ahead of the video-to-AXIS bridge; results are exported to status registers and used to auto-configure downstream VTC parameters.

---
 rtl/video_timing_det_if.sv | 12 +
 rtl/video_timing_det.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_det_if.sv
// rtl/video_timing_det_if.sv - parallel video input stream bundle (data, enable, syncs)
interface video_timing_det_if #(
   parameter int DATA_WIDTH = 16
);
   logic [DATA_WIDTH-1:0] din;
   logic                  en_in;
   logic                  hs_in;
   logic                  vs_in;

   modport master (output din, en_in, hs_in, vs_in);
   modport slave  (input  din, en_in, hs_in, vs_in);
endinterface

// File: rtl/video_timing_det.sv
// rtl/video_timing_det.sv - video timing geometry detector with lock tracking; VIDEO_DET_CHECKSUM_EN adds frame_sum
module video_timing_det #(
   parameter int DATA_WIDTH  = 16,
   parameter int LOCK_FRAMES = 2,
   parameter int TIMEOUT_POW = 24
) (
   input  logic                clk,
   input  logic                rst,
   video_timing_det_if.slave   vid,
   output logic [15:0]         frame_width,
   output logic [15:0]         frame_height,
   output logic [15:0]         active_width,
   output logic [15:0]         active_height,
   output logic [15:0]         hact_start,
   output logic [15:0]         vact_start,
   output logic [15:0]         hsync_width,
   output logic [15:0]         vsync_lines,
   output logic                meas_valid,
   output logic                locked,
   output logic                lock_lost,
   output logic [15:0]         frame_cnt
`ifdef VIDEO_DET_CHECKSUM_EN
   ,
   output logic [31:0]         frame_sum
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_MEAS, S_LOCKED} state_t;

   // Published measurement set; also the reference for the lock comparison.
   typedef struct packed {
      logic [15:0] fw;
      logic [15:0] fh;
      logic [15:0] aw;
      logic [15:0] ah;
      logic [15:0] hst;
      logic [15:0] vst;
      logic [15:0] hsw;
      logic [15:0] vsl;
`ifdef VIDEO_DET_CHECKSUM_EN
      logic [31:0] sum;
`endif
   } meas_t;

   // Statistics of the line currently being received.
   typedef struct packed {
      logic [15:0] hsw;
      logic [15:0] en_cnt;
      logic [15:0] en_st;
      logic [1:0]  en_rises;
   } line_t;

   // Statistics of the frame currently being received.
   typedef struct packed {
      logic        first_done;
      logic        act_seen;
      logic        incons;
      logic        sat;
      logic [15:0] period;
      logic [15:0] aw;
      logic [15:0] ast;
      logic [15:0] ah;
      logic [15:0] vst;
      logic [15:0] hsw;
      logic [15:0] lines;
      logic [15:0] vsl;
      logic [15:0] line_idx;
`ifdef VIDEO_DET_CHECKSUM_EN
      logic [31:0] sum;
`endif
   } acc_t;

   localparam logic [TIMEOUT_POW:0] TO_MAX = {1'b1, {TIMEOUT_POW{1'b0}}};
   localparam logic [3:0]           LOCK_N = 4'(LOCK_FRAMES);

   function automatic logic [15:0] inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic en_q, hs_q, vs_q, en_q2, hs_q2, vs_q2;
`ifdef VIDEO_DET_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] din_q;
`endif
   logic en_rise, hs_rise, vs_rise;

   logic [15:0]      hcnt_q, hcnt_d;
   line_t            ln_q, ln_d;
   acc_t             acc_q, acc_d, le;
   meas_t            pub_q, pub_d, pub_new;
   logic             frame_ok, frame_good;
   state_t           state_q, state_d;
   logic [3:0]       match_q, match_d, match_inc;
   logic             locked_q, locked_d, lock_lost_q, lock_lost_d;
   logic             meas_valid_q, meas_valid_d;
   logic [15:0]      fcnt_q, fcnt_d;
   logic [TIMEOUT_POW:0] to_q, to_d;

   assign en_rise = en_q & ~en_q2;
   assign hs_rise = hs_q & ~hs_q2;
   assign vs_rise = vs_q & ~vs_q2;

   // Input stage: one register for the stream, a second copy for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         en_q  <= 1'b0;
         hs_q  <= 1'b0;
         vs_q  <= 1'b0;
         en_q2 <= 1'b0;
         hs_q2 <= 1'b0;
         vs_q2 <= 1'b0;
`ifdef VIDEO_DET_CHECKSUM_EN
         din_q <= '0;
`endif
      end else begin
         en_q  <= vid.en_in;
         hs_q  <= vid.hs_in;
         vs_q  <= vid.vs_in;
         en_q2 <= en_q;
         hs_q2 <= hs_q;
         vs_q2 <= vs_q;
`ifdef VIDEO_DET_CHECKSUM_EN
         din_q <= vid.din;
`endif
      end
   end

   // Line/frame accumulators: close the line on hs rise first, then open a new frame on vs rise.
   always_comb begin
      hcnt_d = hs_rise ? 16'd0 : inc16(hcnt_q);
      le     = acc_q;
      ln_d   = ln_q;

      if (hs_rise) begin
         if (!le.first_done) begin
            le.first_done = 1'b1;
            le.period     = hcnt_q + 16'd1;
         end else if (hcnt_q + 16'd1 != le.period) begin
            le.incons = 1'b1;
         end
         le.hsw = ln_q.hsw;
         if (ln_q.en_rises > 2'd1) le.incons = 1'b1;
         if (ln_q.en_cnt != 16'd0) begin
            if (!le.act_seen) begin
               le.act_seen = 1'b1;
               le.aw       = ln_q.en_cnt;
               le.ast      = ln_q.en_st;
               le.vst      = acc_q.line_idx;
            end else if (ln_q.en_cnt != le.aw || ln_q.en_st != le.ast) begin
               le.incons = 1'b1;
            end
            le.ah = inc16(le.ah);
         end
         ln_d = '0;
      end

      // The current cycle contributes to the (possibly just opened) line.
      if (hs_q) ln_d.hsw = inc16(ln_d.hsw);
      if (en_q) ln_d.en_cnt = inc16(ln_d.en_cnt);
      if (en_rise) begin
         ln_d.en_st = hcnt_d;
         if (ln_d.en_rises != 2'd2) ln_d.en_rises = ln_d.en_rises + 2'd1;
      end

      pub_new.fw  = le.period;
      pub_new.fh  = le.lines;
      pub_new.aw  = le.aw;
      pub_new.ah  = le.ah;
      pub_new.hst = le.ast;
      pub_new.vst = le.vst;
      pub_new.hsw = le.hsw;
      pub_new.vsl = le.vsl;
`ifdef VIDEO_DET_CHECKSUM_EN
      pub_new.sum = le.sum;
`endif
      frame_ok = !le.incons && !le.sat;

      if (vs_rise) begin
         acc_d       = '0;
         acc_d.lines = hs_rise ? 16'd1 : 16'd0;
         acc_d.vsl   = hs_rise ? 16'd1 : 16'd0;
`ifdef VIDEO_DET_CHECKSUM_EN
         acc_d.sum   = en_q ? 32'(din_q) : 32'd0;
`endif
      end else begin
         acc_d = le;
         if (hs_rise) begin
            acc_d.line_idx = inc16(le.line_idx);
            acc_d.lines    = inc16(le.lines);
            if (vs_q) acc_d.vsl = inc16(le.vsl);
         end
         if (hcnt_d == 16'hFFFF || le.lines == 16'hFFFF) acc_d.sat = 1'b1;
`ifdef VIDEO_DET_CHECKSUM_EN
         if (en_q) acc_d.sum = le.sum + 32'(din_q);
`endif
      end
   end

   // Accumulator registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         hcnt_q <= '0;
         ln_q   <= '0;
         acc_q  <= '0;
      end else begin
         hcnt_q <= hcnt_d;
         ln_q   <= ln_d;
         acc_q  <= acc_d;
      end
   end

   // Lock FSM next state, publish and timeout decisions.
   always_comb begin
      state_d      = state_q;
      pub_d        = pub_q;
      match_d      = match_q;
      locked_d     = locked_q;
      lock_lost_d  = 1'b0;
      meas_valid_d = 1'b0;
      fcnt_d       = fcnt_q;
      to_d         = vs_rise ? '0 : ((to_q == TO_MAX) ? to_q : to_q + 1'b1);
      frame_good   = frame_ok && (pub_new == pub_q);
      match_inc    = (match_q == 4'hF) ? match_q : match_q + 4'd1;

      case (state_q)
         S_IDLE: begin
            if (vs_rise) state_d = S_MEAS;
         end
         S_MEAS, S_LOCKED: begin
            if (vs_rise) begin
               pub_d        = pub_new;
               meas_valid_d = 1'b1;
               fcnt_d       = fcnt_q + 16'd1;
               if (state_q == S_MEAS) begin
                  match_d = frame_good ? match_inc : 4'd0;
                  if (frame_good && match_inc == LOCK_N) begin
                     state_d  = S_LOCKED;
                     locked_d = 1'b1;
                  end
               end else if (!frame_good) begin
                  state_d     = S_MEAS;
                  locked_d    = 1'b0;
                  lock_lost_d = 1'b1;
                  match_d     = 4'd0;
               end
            end else if (to_d == TO_MAX) begin
               state_d     = S_IDLE;
               locked_d    = 1'b0;
               lock_lost_d = locked_q;
               match_d     = 4'd0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM state and published result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         pub_q        <= '0;
         match_q      <= '0;
         locked_q     <= 1'b0;
         lock_lost_q  <= 1'b0;
         meas_valid_q <= 1'b0;
         fcnt_q       <= '0;
         to_q         <= '0;
      end else begin
         state_q      <= state_d;
         pub_q        <= pub_d;
         match_q      <= match_d;
         locked_q     <= locked_d;
         lock_lost_q  <= lock_lost_d;
         meas_valid_q <= meas_valid_d;
         fcnt_q       <= fcnt_d;
         to_q         <= to_d;
      end
   end

   assign frame_width   = pub_q.fw;
   assign frame_height  = pub_q.fh;
   assign active_width  = pub_q.aw;
   assign active_height = pub_q.ah;
   assign hact_start    = pub_q.hst;
   assign vact_start    = pub_q.vst;
   assign hsync_width   = pub_q.hsw;
   assign vsync_lines   = pub_q.vsl;
   assign meas_valid    = meas_valid_q;
   assign locked        = locked_q;
   assign lock_lost     = lock_lost_q;
   assign frame_cnt     = fcnt_q;
`ifdef VIDEO_DET_CHECKSUM_EN
   assign frame_sum     = pub_q.sum;
`endif

endmodule
